// File: rtl/siphash_ctrl_pkg.sv
// Shared definitions for the SipHash message sequencer: FSM encoding and byte-lane masks.
package siphash_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_INIT        = 3'd1,
    ST_ACCEPT      = 3'd2,
    ST_COMP_ISSUE  = 3'd3,
    ST_COMP_WAIT   = 3'd4,
    ST_FINAL_ISSUE = 3'd5,
    ST_FINAL_WAIT  = 3'd6,
    ST_DONE        = 3'd7
  } state_t;

  // Low n bytes kept for a last word carrying n valid bytes.
  localparam logic [63:0] BYTE_MASK [0:8] = '{
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_00ff,
    64'h0000_0000_0000_ffff,
    64'h0000_0000_00ff_ffff,
    64'h0000_0000_ffff_ffff,
    64'h0000_00ff_ffff_ffff,
    64'h0000_ffff_ffff_ffff,
    64'h00ff_ffff_ffff_ffff,
    64'hffff_ffff_ffff_ffff
  };

  function automatic logic [3:0] sat_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/siphash_pad.sv
// Last-block formatter: keeps the valid low bytes of the final word and puts len mod 256 in the top byte.
module siphash_pad
  import siphash_ctrl_pkg::*;
(
  input  logic [63:0] word,
  input  logic [3:0]  nbytes,
  input  logic [7:0]  len_lsb,
  output logic [63:0] mi
);

  logic [3:0] n_sat;

  assign n_sat = sat_bytes(nbytes);

  // Only meaningful for n < 8, where the mask never reaches the length byte.
  always_comb begin
    mi = (word & BYTE_MASK[n_sat]) | {len_lsb, 56'h0};
  end

endmodule

// File: rtl/siphash_msg_ctrl.sv
// Message sequencer for siphash_core: padding, command pulses, digest hand-off.
// Optional start-to-digest cycle counter enabled by SIPHASH_MSG_CTRL_CYCLE_CTR_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for start; config latched on start
// INIT        | one-cycle core_initalize pulse
// ACCEPT      | msg_ready high, next word taken into mi
// COMP_ISSUE  | one-cycle core_compress pulse with core_mi stable
// COMP_WAIT   | wait core_ready; then pad block, finalize or next word
// FINAL_ISSUE | one-cycle core_finalize pulse
// FINAL_WAIT  | wait core_ready & core_word_valid, capture digest
// DONE        | digest_valid high until digest_ready
module siphash_msg_ctrl
  import siphash_ctrl_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [127:0]  key,
  input  logic          long,
  input  logic [3:0]    c_rounds,
  input  logic [3:0]    d_rounds,
  input  logic [63:0]   msg_word,
  input  logic          msg_valid,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic          msg_ready,
  output logic [127:0]  digest,
  output logic          digest_valid,
  input  logic          digest_ready,
  output logic          busy,
  output logic [31:0]   cycle_count,
  output logic          core_initalize,
  output logic          core_compress,
  output logic          core_finalize,
  output logic          core_long,
  output logic [3:0]    core_c_rounds,
  output logic [3:0]    core_d_rounds,
  output logic [127:0]  core_key,
  output logic [63:0]   core_mi,
  input  logic          core_ready,
  input  logic [127:0]  core_word,
  input  logic          core_word_valid
);

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_add;
  logic [63:0]      mi_q;
  logic [63:0]      pad_mi;
  logic             pad_pending;
  logic             fin_pending;
  logic [127:0]     key_q;
  logic             long_q;
  logic [3:0]       c_q;
  logic [3:0]       d_q;
  logic [127:0]     digest_q;
  logic [3:0]       n_sat;
  logic [3:0]       n_step;
  logic             full_last;

  assign n_sat     = sat_bytes(msg_bytes);
  assign n_step    = msg_last ? n_sat : 4'd8;
  assign len_add   = len_q + LEN_W'(n_step);
  assign full_last = msg_last && (n_sat == 4'd8);

  siphash_pad u_pad (
    .word    (msg_word),
    .nbytes  (n_sat),
    .len_lsb (len_add[7:0]),
    .mi      (pad_mi)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    msg_ready      = 1'b0;
    digest_valid   = 1'b0;
    busy           = 1'b1;
    core_initalize = 1'b0;
    core_compress  = 1'b0;
    core_finalize  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        core_initalize = 1'b1;
        state_nxt      = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        msg_ready = 1'b1;
        if (msg_valid) state_nxt = ST_COMP_ISSUE;
      end
      ST_COMP_ISSUE: begin
        core_compress = 1'b1;
        state_nxt     = ST_COMP_WAIT;
      end
      ST_COMP_WAIT: begin
        if (core_ready) begin
          if (pad_pending)      state_nxt = ST_COMP_ISSUE;
          else if (fin_pending) state_nxt = ST_FINAL_ISSUE;
          else                  state_nxt = ST_ACCEPT;
        end
      end
      ST_FINAL_ISSUE: begin
        core_finalize = 1'b1;
        state_nxt     = ST_FINAL_WAIT;
      end
      ST_FINAL_WAIT: begin
        if (core_ready && core_word_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      mi_q        <= '0;
      pad_pending <= 1'b0;
      fin_pending <= 1'b0;
      key_q       <= '0;
      long_q      <= 1'b0;
      c_q         <= '0;
      d_q         <= '0;
      digest_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q       <= key;
            long_q      <= long;
            c_q         <= c_rounds;
            d_q         <= d_rounds;
            len_q       <= '0;
            pad_pending <= 1'b0;
            fin_pending <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (msg_valid) begin
            len_q       <= len_add;
            mi_q        <= (!msg_last || full_last) ? msg_word : pad_mi;
            pad_pending <= full_last;
            fin_pending <= msg_last && !full_last;
          end
        end
        ST_COMP_WAIT: begin
          // A full last word needs one extra block holding only the length byte.
          if (core_ready && pad_pending) begin
            mi_q        <= {len_q[7:0], 56'h0};
            pad_pending <= 1'b0;
            fin_pending <= 1'b1;
          end
        end
        ST_FINAL_WAIT: begin
          if (core_ready && core_word_valid)
            digest_q <= long_q ? core_word : {64'h0, core_word[63:0]};
        end
        default: ;
      endcase
    end
  end

  assign digest        = digest_q;
  assign core_mi       = mi_q;
  assign core_key      = key_q;
  assign core_long     = long_q;
  assign core_c_rounds = c_q;
  assign core_d_rounds = d_q;

`ifdef SIPHASH_MSG_CTRL_CYCLE_CTR_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cyc_q <= '0;
    else if (state == ST_IDLE && start)
      cyc_q <= '0;
    else if (state != ST_IDLE && state != ST_DONE && cyc_q != 32'hFFFF_FFFF)
      cyc_q <= cyc_q + 32'd1;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Directed bench for siphash_msg_ctrl with a behavioural core responder and mi/digest scoreboards.
module tb_siphash_msg_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         long = 1'b0;
  logic [3:0]   c_rounds = '0;
  logic [3:0]   d_rounds = '0;
  logic [63:0]  msg_word = '0;
  logic         msg_valid = 1'b0;
  logic         msg_last = 1'b0;
  logic [3:0]   msg_bytes = '0;
  logic         msg_ready;
  logic [127:0] digest;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         busy;
  logic [31:0]  cycle_count;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic [3:0]   core_c_rounds, core_d_rounds;
  logic [127:0] core_key;
  logic [63:0]  core_mi;
  logic         core_ready = 1'b1;
  logic [127:0] core_word = '0;
  logic         core_word_valid = 1'b0;

  siphash_msg_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .long(long),
    .c_rounds(c_rounds), .d_rounds(d_rounds), .msg_word(msg_word),
    .msg_valid(msg_valid), .msg_last(msg_last), .msg_bytes(msg_bytes),
    .msg_ready(msg_ready), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy), .cycle_count(cycle_count),
    .core_initalize(core_initalize), .core_compress(core_compress),
    .core_finalize(core_finalize), .core_long(core_long),
    .core_c_rounds(core_c_rounds), .core_d_rounds(core_d_rounds),
    .core_key(core_key), .core_mi(core_mi), .core_ready(core_ready),
    .core_word(core_word), .core_word_valid(core_word_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0]  mi_exp_q[$];
  logic [127:0] dig_exp_q[$];
  logic [31:0]  blen;
  int           stall_cycles = 2;
  logic [127:0] next_core_word = '0;
  int           init_cnt = 0, comp_cnt = 0, fin_cnt = 0;
  logic         comp_seen = 1'b0, fin_seen = 1'b0, init_seen = 1'b0;
  logic         prev_comp = 1'b0, prev_fin = 1'b0, prev_init = 1'b0;

  localparam logic [127:0] KEY_A = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] KEY_B = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] last_block(input logic [63:0] w, input int n, input logic [7:0] l);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = w[8*i +: 8];
    r[63:56] = l;
    return r;
  endfunction

  // Monitor: pulse legality and mi scoreboard.
  always @(negedge clk) begin
    comp_seen <= core_compress;
    fin_seen  <= core_finalize;
    init_seen <= core_initalize;
    if (reset_n) begin
      if (core_initalize | core_compress | core_finalize) begin
        check("pulse_onehot", 128'($countones({core_initalize, core_compress, core_finalize})), 128'd1);
        check("pulse_width", {125'h0, prev_init & core_initalize, prev_comp & core_compress,
                              prev_fin & core_finalize}, 128'h0);
      end
      if (core_initalize) init_cnt++;
      if (core_finalize) fin_cnt++;
      if (core_compress) begin
        comp_cnt++;
        if (mi_exp_q.size() == 0) check("mi_unexpected", 128'(core_mi), 128'h0 - 128'd1);
        else check("core_mi", 128'(core_mi), 128'(mi_exp_q.pop_front()));
      end
    end
    prev_init <= core_initalize;
    prev_comp <= core_compress;
    prev_fin  <= core_finalize;
  end

  // Core responder: drops ready after each compress/finalize and returns it stall_cycles later.
  int  core_dly = 0;
  logic core_fin_op = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      core_ready = 1'b1;
      core_word_valid = 1'b0;
      core_dly = 0;
    end else if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) begin
        core_ready = 1'b1;
        if (core_fin_op) begin
          core_word = next_core_word;
          core_word_valid = 1'b1;
        end
      end
    end else if (comp_seen || fin_seen) begin
      core_ready = 1'b0;
      core_word_valid = 1'b0;
      core_fin_op = fin_seen;
      core_dly = stall_cycles;
    end else if (init_seen) begin
      core_word_valid = 1'b0;
    end
  end

  task automatic start_hash(input logic [127:0] k, input logic lg, input logic [3:0] c, input logic [3:0] d);
    key = k; long = lg; c_rounds = c; d_rounds = d; start = 1'b1;
    tick();
    start = 1'b0;
    key = ~k; long = ~lg; c_rounds = ~c; d_rounds = ~d;
    blen = '0;
    tick();
    check("cfg_key", core_key, k);
    check("cfg_long", 128'(core_long), 128'(lg));
    check("cfg_rounds", 128'({core_c_rounds, core_d_rounds}), 128'({c, d}));
  endtask

  task automatic present_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
    int n;
    n = !last ? 8 : ((nb > 4'd8) ? 8 : int'(nb));
    blen = blen + 32'(n);
    if (!last || n == 8) mi_exp_q.push_back(w);
    if (last && n == 8) mi_exp_q.push_back({blen[7:0], 56'h0});
    if (last && n < 8) mi_exp_q.push_back(last_block(w, n, blen[7:0]));
    msg_word = w; msg_last = last; msg_bytes = nb; msg_valid = 1'b1;
  endtask

  task automatic finish_word();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = msg_ready;
    end
    check("msg_handshake", 128'(got), 128'd1);
    tick();
    msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = '0;
  endtask

  task automatic send(input logic [63:0] w, input logic last, input logic [3:0] nb);
    present_word(w, last, nb);
    finish_word();
  endtask

  task automatic set_result(input logic [127:0] cw, input logic lg);
    next_core_word = cw;
    dig_exp_q.push_back(lg ? cw : {64'h0, cw[63:0]});
  endtask

  task automatic wait_digest(input int hold);
    logic got;
    logic [127:0] exp;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = digest_valid;
    end
    check("digest_valid_timeout", 128'(got), 128'd1);
    exp = (dig_exp_q.size() != 0) ? dig_exp_q.pop_front() : 128'hx;
    check("digest", digest, exp);
`ifndef SIPHASH_MSG_CTRL_CYCLE_CTR_EN
    check("cycle_count_tied", 128'(cycle_count), 128'h0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("digest_hold", 128'({digest_valid, busy}), 128'b11);
    end
    @(posedge clk); #1;
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    @(negedge clk);
    check("done_to_idle", 128'({digest_valid, busy}), 128'b00);
    check("digest_retained", digest, exp);
  endtask

  initial begin
    int c0, f0, i0;
    #2;
    repeat (3) @(negedge clk);
    check("rst_outputs", 128'({msg_ready, busy, digest_valid, core_initalize, core_compress,
                               core_finalize, core_long}), 128'h0);
    check("rst_digest", digest, 128'h0);
    check("rst_key", core_key, 128'h0);
    check("rst_mi", 128'(core_mi), 128'h0);
    check("rst_rounds", 128'({core_c_rounds, core_d_rounds}), 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // 15-byte message, 64-bit output
    c0 = comp_cnt; f0 = fin_cnt;
    start_hash(KEY_A, 1'b0, 4'd2, 4'd4);
    set_result({64'hdead_beef_cafe_f00d, 64'ha129ca6149be45e5}, 1'b0);
    send(64'h0706050403020100, 1'b0, 4'd0);
    send(64'h000e0d0c0b0a0908, 1'b1, 4'd7);
    wait_digest(0);
    check("a_pulses", 128'({comp_cnt - c0, fin_cnt - f0}), 128'({32'd2, 32'd1}));

    // empty message
    c0 = comp_cnt;
    start_hash(KEY_A, 1'b0, 4'd2, 4'd4);
    set_result({64'h1111_2222_3333_4444, 64'h726fdb47dd0e0e31}, 1'b0);
    send(64'hffff_ffff_ffff_ffff, 1'b1, 4'd0);
    wait_digest(0);
    check("empty_pulses", 128'(comp_cnt - c0), 128'd1);

    // exactly 8 bytes: data block then length-only block
    c0 = comp_cnt;
    start_hash(KEY_A, 1'b0, 4'd2, 4'd4);
    set_result({64'h5555_6666_7777_8888, 64'h6224939a79f5f593}, 1'b0);
    send(64'h0706050403020100, 1'b1, 4'd8);
    wait_digest(0);
    check("full8_pulses", 128'(comp_cnt - c0), 128'd2);

    // msg_bytes above 8 behaves as 8
    c0 = comp_cnt;
    start_hash(KEY_B, 1'b0, 4'd1, 4'd3);
    set_result(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0);
    send(64'haaaa_bbbb_cccc_dddd, 1'b1, 4'd12);
    wait_digest(0);
    check("bytes12_pulses", 128'(comp_cnt - c0), 128'd2);

    // 128-bit output, 15 bytes, digest held while consumer stalls
    f0 = fin_cnt;
    start_hash(KEY_A, 1'b1, 4'd2, 4'd4);
    set_result(128'h5ea1_4b8d_1c6f_9a72_0b3e_e7c4_d592_86a1, 1'b1);
    send(64'h0706050403020100, 1'b0, 4'd0);
    send(64'h000e0d0c0b0a0908, 1'b1, 4'd7);
    wait_digest(5);
    check("long_fin_once", 128'(fin_cnt - f0), 128'd1);

    // start ignored in ACCEPT and COMP_WAIT; msg_ready low while core is busy
    start_hash(KEY_A, 1'b0, 4'd2, 4'd4);
    i0 = init_cnt;
    key = KEY_B; long = 1'b1; c_rounds = 4'd7; d_rounds = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_in_accept", 128'({busy, msg_ready, core_long}), 128'b110);
    check("key_kept_accept", core_key, KEY_A);
    stall_cycles = 6;
    set_result({64'h9999_0000_9999_0000, 64'h0bad_f00d_0bad_f00d}, 1'b0);
    send(64'h1716151413121110, 1'b0, 4'd0);
    tick();
    present_word(64'h0000_0000_0022_2120, 1'b1, 4'd3);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready_low", 128'({msg_ready, core_ready}), 128'b00);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("key_kept_wait", core_key, KEY_A);
    check("rounds_kept", 128'({core_c_rounds, core_d_rounds, core_long}), 128'({4'd2, 4'd4, 1'b0}));
    finish_word();
    stall_cycles = 2;
    wait_digest(0);
    check("no_reinit", 128'(init_cnt - i0), 128'd0);

    // async reset in COMP_WAIT aborts cleanly
    start_hash(KEY_B, 1'b1, 4'd3, 4'd5);
    stall_cycles = 4;
    send(64'h0102_0304_0506_0708, 1'b0, 4'd0);
    tick();
    c0 = comp_cnt; f0 = fin_cnt; i0 = init_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_abort", 128'({busy, msg_ready, digest_valid, core_compress, core_finalize,
                             core_initalize}), 128'h0);
    check("rst_abort_cfg", core_key, 128'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    stall_cycles = 2;
    repeat (2) tick();
    check("rst_no_pulses", 128'({comp_cnt - c0, fin_cnt - f0, init_cnt - i0}), 128'h0);
    check("rst_mi_queue", 128'(mi_exp_q.size()), 128'd0);

    // fresh hash after the abort
    start_hash(KEY_A, 1'b0, 4'd2, 4'd4);
    set_result({64'h7777_7777_7777_7777, 64'ha129ca6149be45e5}, 1'b0);
    send(64'h0706050403020100, 1'b0, 4'd0);
    send(64'h000e0d0c0b0a0908, 1'b1, 4'd7);
    wait_digest(0);

    repeat (3) tick();
    check("queues_drained", 128'({mi_exp_q.size(), dig_exp_q.size()}), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/siphash_msg_ctrl.md
Name: siphash_msg_ctrl

Overview:
Message sequencer for siphash_core. Accepts a little-endian 64-bit word stream with a last-word byte count, applies SipHash padding, and issues initalize/compress/finalize pulses with core handshaking. Returns a 64- or 128-bit digest on a valid/ready port. Sits between the bus wrapper or DMA stream and siphash_core.

Parameters:
LEN_W, 32, width of the total-message byte counter (wraps mod 2^LEN_W; only bits [7:0] enter padding)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin new hash; sampled only in IDLE
key  in  128  key; k0=[63:0], k1=[127:64]; latched on start
long  in  1  1=128-bit output mode; latched on start
c_rounds  in  4  compression rounds; latched on start
d_rounds  in  4  finalization rounds; latched on start
msg_word  in  64  message word; byte i in [8i+7:8i]
msg_valid  in  1  word valid
msg_last  in  1  final word of message
msg_bytes  in  4  valid bytes in last word, 0..8; ignored when !msg_last
msg_ready  out  1  controller accepts word
digest  out  128  result; [127:64]=0 when !long
digest_valid  out  1  digest held
digest_ready  in  1  consumer takes digest
busy  out  1  not in IDLE
cycle_count  out  32  start-to-digest cycle count (optional feature)
core_initalize, core_compress, core_finalize  out  1 each  core command pulses
core_long  out  1  latched long
core_c_rounds, core_d_rounds  out  4 each  latched round counts
core_key  out  128  latched key
core_mi  out  64  message block to core
core_ready  in  1  core ready
core_word  in  128  core siphash_word
core_word_valid  in  1  core siphash_word_valid

Behaviour:
- Reset: state IDLE; all outputs 0 except msg_ready=0, busy=0; length counter 0; latched config 0.
- IDLE: start -> latch key/long/rounds, len=0 -> INIT. start outside IDLE ignored.
- INIT: core_initalize=1 for one cycle -> ACCEPT.
- ACCEPT: msg_ready=1. On msg_valid&msg_ready:
  - !msg_last: mi=msg_word, len+=8, pad_pending=0 -> COMP_ISSUE.
  - msg_last, msg_bytes=8: mi=msg_word, len+=8, pad_pending=1 -> COMP_ISSUE.
  - msg_last, msg_bytes=n<8: len+=n; mi = {len_new[7:0], bytes 0..n-1 of msg_word, remaining bytes zero}; pad_pending=0, fin_pending=1 -> COMP_ISSUE.
  - msg_bytes 9..15 treated as 8.
- COMP_ISSUE: core_compress=1, core_mi=mi held stable this cycle -> COMP_WAIT.
- COMP_WAIT: wait for core_ready=1 (core drops ready the cycle after issue). Then: pad_pending -> mi={len[7:0],56'h0}, pad_pending=0, fin_pending=1 -> COMP_ISSUE; fin_pending -> FINAL_ISSUE; else -> ACCEPT.
- FINAL_ISSUE: core_finalize=1 -> FINAL_WAIT.
- FINAL_WAIT: on core_ready & core_word_valid -> digest = long ? core_word : {64'h0, core_word[63:0]} -> DONE.
- DONE: digest_valid=1 until digest_ready; then -> IDLE, digest_valid=0 next cycle. digest retains value until next FINAL_WAIT capture.
- Command pulses are mutually exclusive and exactly one cycle wide.
- Empty message: msg_last with msg_bytes=0 gives one block {8'h00,56'h0}.
- Length wraps mod 2^LEN_W; padding uses len mod 256.
- Async reset mid-operation aborts to IDLE; the core shares the reset.

Optional Feature:
SIPHASH_MSG_CTRL_CYCLE_CTR_EN: when defined, 32-bit counter clears on start acceptance and increments each cycle in non-IDLE/non-DONE states, saturating at 32'hFFFFFFFF; the value holds in DONE and drives cycle_count. When undefined, cycle_count is tied to 0 and no counter flops exist.

Decomposition:
- Package siphash_ctrl_pkg: state encoding (IDLE, INIT, ACCEPT, COMP_ISSUE, COMP_WAIT, FINAL_ISSUE, FINAL_WAIT, DONE) and the byte-lane mask constant for n=0..8.
- Sub-module siphash_pad: combinational last-block formatter (msg_word, n, len[7:0] -> mi).

Test Plan:
- Key k0=64'h0706050403020100, k1=64'h0f0e0d0c0b0a0908, c=2, d=4, !long, words 64'h0706050403020100 and 64'h000e0d0c0b0a0908 (last, bytes=7) -> core_mi of second block 64'h0f0e0d0c0b0a0908; digest 64'ha129ca6149be45e5.
- Same key, empty message (msg_last, bytes=0) -> one compress with mi=0; digest 64'h726fdb47dd0e0e31.
- Same key, 8-byte message (bytes=8) -> two compress pulses, second mi=64'h0800000000000000; digest matches the software model.
- long=1, 15-byte message -> finalize once; digest[127:64] nonzero and matches the SipHash-128 model; digest_valid holds for 5 cycles while digest_ready=0.
- start pulsed during ACCEPT and during COMP_WAIT -> ignored; config unchanged; msg_valid stalls in COMP_WAIT -> msg_ready=0 until core_ready returns.
- reset_n asserted in COMP_WAIT -> next edge IDLE, busy=0, no command pulses; a new hash afterwards gives a correct digest.
